// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, segment
// bit order and the scan state encoding.
package seven_seg_pkg;

  // Segment bus is {g,f,e,d,c,b,a}: a is the LSB, g the MSB.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_G = 6;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_e;

  localparam logic [15:0][SEG_G:SEG_A] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_G:SEG_A] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-to-segment decode with a blank override, active-high.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0]         nibble_i,
  input  logic               blank_i,
  output logic [SEG_G:SEG_A] seg_o
);

  always_comb begin
    seg_o = '0;
    if (!blank_i) begin
      seg_o = hex_to_seg(nibble_i);
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned value loading,
// inter-digit blanking and leading-zero suppression.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  update_value,
  input  logic                  lz_blank,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_out,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam scan_state_e      SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic [6:0]        SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF   = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  scan_state_e         state_q, state_d;
  logic [4*DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_done_q, frame_done_d;

  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank, seen_nz;
  logic [DIGITS-1:0]   lz_mask, dig_onehot;
  logic [6:0]          seg_dec;

  always_comb begin
    wrap    = (cnt_q == LAST_CNT);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == LAST_BLANK) state_d = SHOW;
      SHOW:    if (wrap) state_d = SLOT_START;
      default: state_d = SLOT_START;
    endcase
    // Registered so the pulse lands on the last cycle of the last slot itself.
    frame_done_d = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
  end

  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    pending_d   = pending_q;
    if (frame_done_q) begin
      pending_d = 1'b0;
      if (update_value) begin
        active_d    = value_in;
        active_dp_d = dp_in;
      end else if (pending_q) begin
        active_d    = shadow_q;
        active_dp_d = shadow_dp_q;
      end
    end else if (update_value) begin
      shadow_d    = value_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    seen_nz = 1'b0;
    lz_mask = '0;
    // Walk from the most significant digit down; digit 0 is never masked.
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      if (active_q[4*(DIGITS-1-k) +: 4] != 4'h0) seen_nz = 1'b1;
      lz_mask[DIGITS-1-k] = lz_blank && !seen_nz;
    end
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    dig_onehot = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib       = active_q[4*i +: 4];
        cur_dp        = active_dp_q[i];
        cur_blank     = lz_mask[i];
        dig_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_decode u_decode (
    .nibble_i (cur_nib),
    .blank_i  (cur_blank),
    .seg_o    (seg_dec)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = SEG_ACTIVE_LOW;
    dig_d = DIG_OFF;
    if (state_q == SHOW) begin
      seg_d = seg_dec ^ SEG_OFF;
      dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
      dig_d = dig_onehot ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= SLOT_START;
      active_q     <= '0;
      active_dp_q  <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACTIVE_LOW;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_out    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a frame model pushes expected
// digit slots, a pin monitor pops and checks them as the DUT scans.
module tb_seven_seg_scan_driver;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned FRAME        = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        update_value = 1'b0;
  logic        lz_blank = 1'b0;

  logic [6:0]  seg_out, pol_seg_out;
  logic        dp_out, pol_dp_out;
  logic [3:0]  dig_out, pol_dig_out;
  logic        frame_done, pol_frame_done;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
    .update_value(update_value), .lz_blank(lz_blank), .seg_out(seg_out),
    .dp_out(dp_out), .dig_out(dig_out), .frame_done(frame_done)
  );

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_pol (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in),
    .update_value(update_value), .lz_blank(lz_blank), .seg_out(pol_seg_out),
    .dp_out(pol_dp_out), .dig_out(pol_dig_out), .frame_done(pol_frame_done)
  );

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;

  int unsigned m_cyc = 0;
  logic [15:0] m_active = '0, m_shadow = '0;
  logic [3:0]  m_active_dp = '0, m_shadow_dp = '0;
  logic        m_pend = 1'b0;

  logic        mon_en = 1'b0;
  logic [3:0]  mon_prev = '0;
  int          mon_len = 0;
  exp_t        mon_cur = '0;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  function automatic void push_frame();
    logic [3:0] blank;
    logic       seen;
    exp_t       e;
    seen  = 1'b0;
    blank = '0;
    for (int d = 3; d >= 1; d--) begin
      if (m_active[4*d +: 4] != 4'h0) seen = 1'b1;
      blank[d] = lz_blank && !seen;
    end
    for (int d = 0; d < 4; d++) begin
      e.dig = 4'(1 << d);
      e.seg = blank[d] ? 7'h00 : hexseg(m_active[4*d +: 4]);
      e.dp  = m_active_dp[d];
      sb.push_back(e);
    end
  endfunction

  // Pin monitor: each new active run pops one expected slot.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dig_out != 4'b0000) begin
        if (mon_prev == 4'b0000) begin
          vectors++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: slot started at cycle %0d, expected an entry queued", m_cyc);
            mon_cur = '0;
          end else begin
            mon_cur = sb.pop_front();
          end
          vectors++;
          if ((m_cyc % SCAN_DIV) != 3) begin
            errors++;
            $display("FAIL slot_phase: slot began at phase %0d, expected 3", m_cyc % SCAN_DIV);
          end
          mon_len = 0;
        end
        mon_len++;
        vectors++;
        if ({dig_out, seg_out, dp_out} !== mon_cur) begin
          errors++;
          $display("FAIL slot_out: cyc %0d dig=%b seg=%b dp=%b, expected dig=%b seg=%b dp=%b",
                   m_cyc, dig_out, seg_out, dp_out, mon_cur.dig, mon_cur.seg, mon_cur.dp);
        end
      end else begin
        if (mon_prev != 4'b0000) begin
          vectors++;
          if (mon_len != int'(SCAN_DIV - BLANK_CYCLES)) begin
            errors++;
            $display("FAIL slot_len: got %0d cycles, expected %0d", mon_len, SCAN_DIV - BLANK_CYCLES);
          end
        end
        vectors++;
        if (seg_out !== 7'h00 || dp_out !== 1'b0) begin
          errors++;
          $display("FAIL blank_seg: cyc %0d seg=%b dp=%b, expected 0000000/0", m_cyc, seg_out, dp_out);
        end
      end
      mon_prev = dig_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    if (m_cyc % FRAME == FRAME - 1) begin
      if (update_value) begin
        m_active = value_in;  m_active_dp = dp_in;
      end else if (m_pend) begin
        m_active = m_shadow;  m_active_dp = m_shadow_dp;
      end
      m_pend = 1'b0;
      push_frame();
    end else if (update_value) begin
      m_shadow = value_in;  m_shadow_dp = dp_in;  m_pend = 1'b1;
    end
    m_cyc++;
    @(negedge clk);
    vectors++;
    if (frame_done !== (m_cyc % FRAME == FRAME - 1)) begin
      errors++;
      $display("FAIL frame_done: cyc %0d got %b, expected %b", m_cyc, frame_done, (m_cyc % FRAME == FRAME - 1));
    end
  endtask

  task automatic goto_phase(input int unsigned p);
    while (m_cyc % FRAME != p) tick();
  endtask

  task automatic do_update(input logic [15:0] v, input logic [3:0] dp);
    value_in = v;  dp_in = dp;  update_value = 1'b1;
    tick();
    update_value = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    m_cyc    = 0;
    m_active = '0;  m_active_dp = '0;  m_pend = 1'b0;
    sb.delete();
    push_frame();
    mon_prev = '0;
    mon_en   = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (dig_out !== 4'b0000 || seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_main: dig=%b seg=%b dp=%b fd=%b, expected all 0", tag, dig_out, seg_out, dp_out, frame_done);
    end
    vectors++;
    if (pol_dig_out !== 4'b1111 || pol_seg_out !== 7'h7F || pol_dp_out !== 1'b1 || pol_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pol: dig=%b seg=%b dp=%b fd=%b, expected 1111/1111111/1/0", tag, pol_dig_out, pol_seg_out, pol_dp_out, pol_frame_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle("reset");
    release_reset();
  endtask

  task automatic test_idle_scan();
    repeat (2 * FRAME) tick();
  endtask

  task automatic test_update_mid_frame();
    goto_phase(10);
    do_update(16'h12AF, 4'b0100);
    goto_phase(0);
    repeat (FRAME) tick();
  endtask

  task automatic test_back_to_back();
    goto_phase(5);
    do_update(16'h1111, 4'b0001);
    goto_phase(20);
    do_update(16'h2222, 4'b0000);
    goto_phase(0);
    repeat (FRAME) tick();
    goto_phase(FRAME - 1);
    do_update(16'h3333, 4'b1000);
    repeat (FRAME) tick();
  endtask

  task automatic test_lz_blank();
    lz_blank = 1'b1;
    goto_phase(8);
    do_update(16'h0050, 4'b0000);
    goto_phase(0);
    goto_phase(12);
    vectors++;
    if (dig_out !== 4'b0010 || seg_out !== 7'b1101101) begin
      errors++;
      $display("FAIL lz_digit1: dig=%b seg=%b, expected 0010/1101101", dig_out, seg_out);
    end
    goto_phase(28);
    vectors++;
    if (dig_out !== 4'b1000 || seg_out !== 7'h00) begin
      errors++;
      $display("FAIL lz_digit3: dig=%b seg=%b, expected 1000/0000000", dig_out, seg_out);
    end
    goto_phase(8);
    do_update(16'h0000, 4'b0000);
    goto_phase(0);
    goto_phase(4);
    vectors++;
    if (dig_out !== 4'b0001 || seg_out !== 7'b0111111) begin
      errors++;
      $display("FAIL lz_zero_d0: dig=%b seg=%b, expected 0001/0111111", dig_out, seg_out);
    end
    goto_phase(20);
    vectors++;
    if (dig_out !== 4'b0100 || seg_out !== 7'h00) begin
      errors++;
      $display("FAIL lz_zero_d2: dig=%b seg=%b, expected 0100/0000000", dig_out, seg_out);
    end
    goto_phase(0);
  endtask

  task automatic test_polarity();
    goto_phase(8);
    do_update(16'h8888, 4'b0000);
    goto_phase(0);
    goto_phase(4);
    vectors++;
    if (pol_seg_out !== 7'b0000000 || pol_dig_out !== 4'b1110 || pol_dp_out !== 1'b1) begin
      errors++;
      $display("FAIL polarity: seg=%b dig=%b dp=%b, expected 0000000/1110/1", pol_seg_out, pol_dig_out, pol_dp_out);
    end
    vectors++;
    if (seg_out !== 7'b1111111 || dig_out !== 4'b0001) begin
      errors++;
      $display("FAIL polarity_ref: seg=%b dig=%b, expected 1111111/0001", seg_out, dig_out);
    end
    goto_phase(0);
  endtask

  task automatic test_reset_mid_frame();
    goto_phase(2);
    do_update(16'h5555, 4'b1111);
    goto_phase(20);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_idle("reset_mid");
    release_reset();
    repeat (3) tick();
    vectors++;
    if (dig_out !== 4'b0001 || seg_out !== 7'b0111111) begin
      errors++;
      $display("FAIL reset_restart: dig=%b seg=%b, expected 0001/0111111", dig_out, seg_out);
    end
    repeat (2 * FRAME) tick();
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_update_mid_frame();
    test_back_to_back();
    test_lz_blank();
    test_polarity();
    test_reset_mid_frame();
    vectors++;
    if (sb.size() > 4) begin
      errors++;
      $display("FAIL sb_leftover: %0d slots never displayed, expected at most 4", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
